// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: status codes, FSM state encodings and icode constants for the fetch controller
package fetch_ctrl_pkg;
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_RET = 2'd2,
        HALT     = 2'd3
    } state_e;
    localparam logic [3:0] ICODE_HALT = 4'd0;
    localparam logic [3:0] ICODE_JXX  = 4'd7;
    localparam logic [3:0] ICODE_CALL = 4'd8;
    localparam logic [3:0] ICODE_RET  = 4'd9;
    function automatic logic predict_taken(input logic [3:0] icode);
        return icode == ICODE_JXX || icode == ICODE_CALL;
    endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-stage, decode-handshake, redirect and status signals of the fetch controller
// master: the controller (drives pc_o, f_valid_o, stat_o, state_o, counters); slave: its environment
interface fetch_ctrl_if;
    logic        start_i;
    logic [63:0] start_pc_i;
    logic [63:0] pc_o;
    logic [3:0]  icode_i;
    logic [63:0] valC_i;
    logic [63:0] valP_i;
    logic        instr_valid_i;
    logic        imem_error_i;
    logic        f_valid_o;
    logic        d_ready_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [2:0]  stat_o;
    logic [1:0]  state_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
    modport master (
        input  start_i, start_pc_i, icode_i, valC_i, valP_i, instr_valid_i, imem_error_i,
               d_ready_i, redirect_i, redirect_pc_i,
        output pc_o, f_valid_o, stat_o, state_o, fetch_cnt_o, stall_cnt_o
    );
    modport slave (
        output start_i, start_pc_i, icode_i, valC_i, valP_i, instr_valid_i, imem_error_i,
               d_ready_i, redirect_i, redirect_pc_i,
        input  pc_o, f_valid_o, stat_o, state_o, fetch_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/fetch_ctrl_pc_predict.sv
// pc_predict: next-PC selection, valC_i for jXX/call (predict taken), valP_i otherwise
// ports: icode_i, valC_i, valP_i in; next_pc_o out
module pc_predict
    import fetch_ctrl_pkg::*;
(
    input  logic [3:0]  icode_i,
    input  logic [63:0] valC_i,
    input  logic [63:0] valP_i,
    output logic [63:0] next_pc_o
);
    assign next_pc_o = predict_taken(icode_i) ? valC_i : valP_i;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing FSM (IDLE/RUN/WAIT_RET/HALT) with decode handshake and redirects
// ports: clk_i, rst_i (async, active-high), bus (fetch_ctrl_if.master)
// FETCH_CTRL_PERF_EN enables the fetch/stall counters; otherwise they read 0
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int IMEM_SIZE = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_ctrl_if.master bus
);
    if (IMEM_SIZE <= 0) begin : g_bad_imem_size
        $error("fetch_ctrl: IMEM_SIZE must be positive");
    end
    state_e      state;
    stat_e       stat;
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic        f_valid;
    logic        transfer;
    // a redirect squashes whatever the fetch stage is offering this cycle
    assign f_valid  = state == RUN && !bus.redirect_i;
    assign transfer = f_valid && bus.d_ready_i;
    pc_predict u_pc_predict (
        .icode_i   (bus.icode_i),
        .valC_i    (bus.valC_i),
        .valP_i    (bus.valP_i),
        .next_pc_o (next_pc)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            stat  <= STAT_AOK;
            pc    <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.start_i) begin
                        pc    <= bus.start_pc_i;
                        stat  <= STAT_AOK;
                        state <= RUN;
                    end
                end
                default: begin
                    if (bus.redirect_i) begin
                        pc    <= bus.redirect_pc_i;
                        state <= RUN;
                    end else if (transfer) begin
                        if (bus.imem_error_i) begin
                            stat  <= STAT_ADR;
                            state <= HALT;
                        end else if (!bus.instr_valid_i) begin
                            stat  <= STAT_INS;
                            state <= HALT;
                        end else if (bus.icode_i == ICODE_HALT) begin
                            stat  <= STAT_HLT;
                            state <= HALT;
                        end else begin
                            pc <= next_pc;
                            if (bus.icode_i == ICODE_RET) state <= WAIT_RET;
                        end
                    end
                end
            endcase
        end
    end
    assign bus.pc_o      = pc;
    assign bus.f_valid_o = f_valid;
    assign bus.stat_o    = stat;
    assign bus.state_o   = state;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (transfer) fetch_cnt <= fetch_cnt + 32'd1;
            if ((f_valid && !bus.d_ready_i) || state == WAIT_RET) stall_cnt <= stall_cnt + 32'd1;
        end
    end
    assign bus.fetch_cnt_o = fetch_cnt;
    assign bus.stall_cnt_o = stall_cnt;
`else
    assign bus.fetch_cnt_o = '0;
    assign bus.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, reset corner cases and randomized run against a reference model
module tb_fetch_ctrl;
`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fetch_ctrl_if bus();
    fetch_ctrl #(.IMEM_SIZE(1024)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );
    int tests = 0;
    int fails = 0;
    int          m_st;
    int          m_stat;
    logic [63:0] m_pc;
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    typedef struct {
        logic        start;
        logic [63:0] spc;
        logic [3:0]  icode;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        iv;
        logic        ie;
        logic        dr;
        logic        rd;
        logic [63:0] rpc;
        logic [63:0] e_pc;
        int          e_st;
        int          e_stat;
        logic        e_fv;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_st = 0; m_stat = 1; m_pc = '0; m_fc = '0; m_sc = '0;
    endtask
    // state names: 0 idle, 1 run, 2 waiting for ret target, 3 halted
    task automatic model_step();
        logic fv, xf;
        fv = m_st == 1 && !bus.redirect_i;
        xf = fv && bus.d_ready_i;
        if (PERF) begin
            if (xf) m_fc = m_fc + 1;
            if ((fv && !bus.d_ready_i) || m_st == 2) m_sc = m_sc + 1;
        end
        if (m_st == 0 || m_st == 3) begin
            if (bus.start_i) begin m_pc = bus.start_pc_i; m_stat = 1; m_st = 1; end
        end else if (bus.redirect_i) begin
            m_pc = bus.redirect_pc_i; m_st = 1;
        end else if (xf) begin
            if (bus.imem_error_i)           begin m_stat = 3; m_st = 3; end
            else if (!bus.instr_valid_i)    begin m_stat = 4; m_st = 3; end
            else if (bus.icode_i == 4'd0)   begin m_stat = 2; m_st = 3; end
            else if (bus.icode_i == 4'd9)   begin m_pc = bus.valP_i; m_st = 2; end
            else if (bus.icode_i == 4'd7 || bus.icode_i == 4'd8) m_pc = bus.valC_i;
            else m_pc = bus.valP_i;
        end
    endtask
    task automatic check_model(input string tag);
        chk({tag, ".pc"}, bus.pc_o, m_pc);
        chk({tag, ".state"}, 64'(bus.state_o), 64'(m_st));
        chk({tag, ".stat"}, 64'(bus.stat_o), 64'(m_stat));
        chk({tag, ".f_valid"}, 64'(bus.f_valid_o), 64'(m_st == 1 && !bus.redirect_i));
        chk({tag, ".fetch_cnt"}, 64'(bus.fetch_cnt_o), 64'(m_fc));
        chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt_o), 64'(m_sc));
    endtask
    task automatic drive(input vec_t v);
        bus.start_i = v.start; bus.start_pc_i = v.spc; bus.icode_i = v.icode;
        bus.valC_i = v.valc; bus.valP_i = v.valp; bus.instr_valid_i = v.iv;
        bus.imem_error_i = v.ie; bus.d_ready_i = v.dr; bus.redirect_i = v.rd;
        bus.redirect_pc_i = v.rpc;
    endtask
    task automatic idle_inputs();
        bus.start_i = 0; bus.start_pc_i = '0; bus.icode_i = 4'd1; bus.valC_i = '0;
        bus.valP_i = '0; bus.instr_valid_i = 1; bus.imem_error_i = 0; bus.d_ready_i = 0;
        bus.redirect_i = 0; bus.redirect_pc_i = '0;
    endtask
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask
    initial begin
        //                start spc              icode valc     valp      iv ie dr rd rpc       e_pc                 st stat fv
        vecs.push_back('{1, 64'h100, 6, 0,       0,        1, 0, 0, 0, 0,        64'h100,             1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       64'h102,  1, 0, 1, 0, 0,        64'h102,             1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       64'h200,  1, 0, 0, 0, 0,        64'h102,             1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       64'h200,  1, 0, 0, 0, 0,        64'h102,             1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       64'h200,  1, 0, 0, 0, 0,        64'h102,             1, 1, 1});
        vecs.push_back('{0, 0,       7, 64'h40,  64'h104,  1, 0, 1, 0, 0,        64'h40,              1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       64'h999,  1, 0, 1, 1, 64'h10A,  64'h10A,             1, 1, 0});
        vecs.push_back('{0, 0,       9, 64'h55,  64'h10C,  1, 0, 1, 0, 0,        64'h10C,             2, 1, 0});
        vecs.push_back('{0, 0,       6, 0,       64'h777,  1, 0, 1, 0, 0,        64'h10C,             2, 1, 0});
        vecs.push_back('{0, 0,       6, 0,       64'h777,  1, 0, 1, 0, 0,        64'h10C,             2, 1, 0});
        vecs.push_back('{0, 0,       6, 0,       64'h777,  1, 0, 1, 0, 0,        64'h10C,             2, 1, 0});
        vecs.push_back('{0, 0,       6, 0,       64'h777,  1, 0, 1, 1, 64'h200,  64'h200,             1, 1, 0});
        vecs.push_back('{0, 0,       8, 64'h300, 64'h209,  1, 0, 1, 0, 0,        64'h300,             1, 1, 1});
        vecs.push_back('{0, 0,       0, 0,       0,        0, 1, 1, 0, 0,        64'h300,             3, 3, 0});
        vecs.push_back('{0, 0,       6, 0,       0,        1, 0, 1, 1, 64'h500,  64'h300,             3, 3, 0});
        vecs.push_back('{1, 64'h600, 6, 0,       0,        1, 0, 0, 0, 0,        64'h600,             1, 1, 1});
        vecs.push_back('{0, 0,       0, 0,       0,        0, 0, 1, 0, 0,        64'h600,             3, 4, 0});
        vecs.push_back('{1, 64'h700, 6, 0,       0,        1, 0, 0, 0, 0,        64'h700,             1, 1, 1});
        vecs.push_back('{1, 64'h800, 6, 0,       64'h704,  1, 0, 1, 0, 0,        64'h704,             1, 1, 1});
        vecs.push_back('{0, 0,       0, 0,       0,        1, 0, 1, 0, 0,        64'h704,             3, 2, 0});
        vecs.push_back('{1, 64'hFFFF_FFFF_FFFF_FFFE, 6, 0, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 1});
        vecs.push_back('{0, 0,       6, 0,       0,        1, 0, 1, 0, 0,        64'h0,               1, 1, 1});
        idle_inputs();
        model_reset();
        #12;
        check_model("reset");
        rst = 0;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            chk($sformatf("vec%0d.pc", i), bus.pc_o, vecs[i].e_pc);
            chk($sformatf("vec%0d.state", i), 64'(bus.state_o), 64'(vecs[i].e_st));
            chk($sformatf("vec%0d.stat", i), 64'(bus.stat_o), 64'(vecs[i].e_stat));
            chk($sformatf("vec%0d.f_valid", i), 64'(bus.f_valid_o), 64'(vecs[i].e_fv));
            chk($sformatf("vec%0d.fetch_cnt", i), 64'(bus.fetch_cnt_o), 64'(m_fc));
            chk($sformatf("vec%0d.stall_cnt", i), 64'(bus.stall_cnt_o), 64'(m_sc));
            if (i == 4) chk("stall_after_3", 64'(bus.stall_cnt_o), PERF ? 64'd3 : 64'd0);
        end
        idle_inputs();
        bus.start_i = 1; bus.start_pc_i = 64'h900;
        step();
        check_model("seq_start");
        idle_inputs();
        bus.icode_i = 4'd9; bus.valP_i = 64'h908; bus.d_ready_i = 1;
        step();
        chk("seq_ret.state", 64'(bus.state_o), 64'd2);
        check_model("seq_ret");
        idle_inputs();
        bus.redirect_i = 1; bus.redirect_pc_i = 64'hA00;
        #2 rst = 1;
        #1;
        model_reset();
        chk("async_rst.pc", bus.pc_o, 64'h0);
        chk("async_rst.state", 64'(bus.state_o), 64'd0);
        chk("async_rst.stat", 64'(bus.stat_o), 64'd1);
        chk("async_rst.f_valid", 64'(bus.f_valid_o), 64'd0);
        check_model("async_rst");
        @(posedge clk);
        #1 rst = 0;
        step();
        chk("post_rst_redirect.pc", bus.pc_o, 64'h0);
        chk("post_rst_redirect.state", 64'(bus.state_o), 64'd0);
        check_model("post_rst");
        idle_inputs();
        bus.start_i = 1; bus.start_pc_i = 64'h1000;
        step();
        idle_inputs();
        bus.icode_i = 4'd0; bus.d_ready_i = 1;
        step();
        chk("hlt.stat", 64'(bus.stat_o), 64'd2);
        idle_inputs();
        #2 rst = 1;
        #1;
        model_reset();
        chk("hlt_rst.stat", 64'(bus.stat_o), 64'd1);
        chk("hlt_rst.state", 64'(bus.state_o), 64'd0);
        check_model("hlt_rst");
        @(posedge clk);
        #1 rst = 0;
        for (int n = 0; n < 3000; n++) begin
            bus.start_i       = ($urandom % 8) == 0;
            bus.start_pc_i    = {$urandom, $urandom};
            bus.icode_i       = 4'($urandom % 16);
            bus.valC_i        = {$urandom, $urandom};
            bus.valP_i        = {$urandom, $urandom};
            bus.instr_valid_i = ($urandom % 8) != 0;
            bus.imem_error_i  = ($urandom % 16) == 0;
            bus.d_ready_i     = ($urandom % 4) != 0;
            bus.redirect_i    = ($urandom % 8) == 0;
            bus.redirect_pc_i = {$urandom, $urandom};
            step();
            check_model($sformatf("rand%0d", n));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter IMEM_SIZE, default 1024, instruction-memory size in bytes, informational for the bench only.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start_i  input  1  begin fetching at start_pc_i.
REQ-005 SHALL have port start_pc_i  input  64  program entry address.
REQ-006 SHALL have port pc_o  output  64  address driven to the fetch stage.
REQ-007 SHALL have port icode_i  input  4  opcode from the fetch stage.
REQ-008 SHALL have port valC_i  input  64  constant word from the fetch stage.
REQ-009 SHALL have port valP_i  input  64  sequential next PC from the fetch stage.
REQ-010 SHALL have port instr_valid_i  input  1  opcode legal.
REQ-011 SHALL have port imem_error_i  input  1  fetch address out of range.
REQ-012 SHALL have port f_valid_o  output  1  fetched instruction offered to decode.
REQ-013 SHALL have port d_ready_i  input  1  decode accepts the instruction.
REQ-014 SHALL have port redirect_i  input  1  PC correction from a later stage (mispredict or ret).
REQ-015 SHALL have port redirect_pc_i  input  64  corrected PC.
REQ-016 SHALL have port stat_o  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-017 SHALL have port state_o  output  2  FSM state: IDLE=0, RUN=1, WAIT_RET=2, HALT=3.
REQ-018 SHALL have ports fetch_cnt_o and stall_cnt_o  output  32 each  performance counters.

Function
REQ-019 SHALL use transfer = f_valid_o && d_ready_i.
REQ-020 SHALL drive f_valid_o = (state==RUN) && !redirect_i, combinationally.
REQ-021 In IDLE, start_i=1 SHALL load pc_o <= start_pc_i, set stat_o to AOK, and enter RUN on the next cycle.
REQ-022 In RUN with no transfer and no redirect, pc_o and state SHALL hold.
REQ-023 On transfer with imem_error_i=1, the block SHALL set stat_o=ADR and enter HALT; pc_o SHALL hold.
REQ-024 Otherwise, on transfer with instr_valid_i=0, the block SHALL set stat_o=INS and enter HALT.
REQ-025 Otherwise, on transfer with icode_i=0 (halt), the block SHALL set stat_o=HLT and enter HALT.
REQ-026 Otherwise, on transfer with icode_i=9 (ret), the block SHALL set pc_o <= valP_i and enter WAIT_RET.
REQ-027 Otherwise, on transfer with icode_i=7 (jXX) or 8 (call), the block SHALL set pc_o <= valC_i (predict taken).
REQ-028 Otherwise, on transfer, the block SHALL set pc_o <= valP_i.
REQ-029 Precedence within one cycle SHALL be ADR > INS > HLT.
REQ-030 In WAIT_RET, f_valid_o SHALL be 0 and pc_o SHALL hold until redirect_i.
REQ-031 In RUN or WAIT_RET, redirect_i=1 SHALL load pc_o <= redirect_pc_i and go to RUN, overriding any same-cycle transfer (the instruction is squashed since f_valid_o=0).
REQ-032 redirect_i SHALL be ignored in IDLE and HALT.
REQ-033 start_i SHALL be ignored in RUN and WAIT_RET.
REQ-034 In HALT, start_i SHALL restart exactly as in IDLE.
REQ-035 PC arithmetic SHALL be 64-bit with natural wrap; no range check SHALL be performed here.
REQ-036 Latency SHALL be one cycle from event to the new pc_o.

Reset
REQ-037 rst_i SHALL immediately force state IDLE, pc_o=0, stat_o=AOK, f_valid_o=0, and both counters to 0, independent of clk_i.
REQ-038 Reset mid-operation SHALL discard any pending ret or redirect.

Configuration
REQ-039 With FETCH_CTRL_PERF_EN defined, fetch_cnt_o SHALL increment on each transfer.
REQ-040 With FETCH_CTRL_PERF_EN defined, stall_cnt_o SHALL increment each cycle in RUN with f_valid_o && !d_ready_i, or in WAIT_RET.
REQ-041 With FETCH_CTRL_PERF_EN defined, both counters SHALL wrap at 2^32.
REQ-042 Without FETCH_CTRL_PERF_EN, both counter ports SHALL exist and be tied to 0.

Structure
REQ-043 A shared package SHALL hold the stat codes, FSM state encodings, and icode constants (HALT=0, JXX=7, CALL=8, RET=9).
REQ-044 One sub-module, pc_predict (combinational selection of valC_i or valP_i), is natural; the FSM SHALL stay in fetch_ctrl.

Verification
REQ-045 Scenario: reset, then start_i with start_pc_i=0x100 -> state_o=RUN and pc_o=0x100 next cycle.
REQ-046 Scenario: icode 6, valP=0x102, d_ready=1 -> pc_o=0x102; with d_ready=0 for 3 cycles -> pc_o holds and stall_cnt_o=3.
REQ-047 Scenario: icode 7, valC=0x40 -> pc_o=0x40; then redirect_pc_i=0x10A -> pc_o=0x10A with f_valid_o=0 in the redirect cycle.
REQ-048 Scenario: icode 9 -> WAIT_RET with f_valid_o=0; redirect_pc_i=0x200 after 4 cycles -> RUN, pc_o=0x200.
REQ-049 Scenario: imem_error_i=1 and instr_valid_i=0 on the same transfer -> stat_o=ADR and HALT; a redirect in HALT is ignored.
REQ-050 Scenario: icode 0 -> stat_o=HLT; rst_i asserted mid-cycle -> outputs clear asynchronously.
